load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Multi-cycle initiator for the byte-addressed data memory (word/byte-op port, combinational read,
//  negedge write). Accepts one CPU load/store per handshake, sequences it into word or byte memory
//  ops, assembles and sign/zero-extends load data, returns a one-cycle response. Sits between the
//  execute stage and data memory; gives the core full RV32I LB/LH/LW/LBU/LHU/SB/SH/SW.
// PARAMETERS
//  DATA_WIDTH  32  CPU data and memory word width
//  BYTE_WIDTH  8   memory byte width; DATA_WIDTH/BYTE_WIDTH bytes per word
//  ADDR_WIDTH  32  byte address width
// PORTS
//  clk_i          in   1           clock; all state on posedge
//  rst_ni         in   1           asynchronous, active-low reset
//  req_valid_i    in   1           CPU request valid
//  req_ready_o    out  1           high only in IDLE; accept = req_valid_i & req_ready_o
//  req_we_i       in   1           1 = store, 0 = load
//  req_funct3_i   in   3           RV32I funct3 (width/signedness)
//  req_addr_i     in   ADDR_WIDTH  byte address
//  req_wdata_i    in   DATA_WIDTH  store data (low bytes used for SB/SH)
//  rsp_valid_o    out  1           one-cycle response pulse
//  rsp_rdata_o    out  DATA_WIDTH  extended load data; 0 for stores and errors
//  rsp_err_o      out  1           illegal funct3 or unsupported misalignment
//  mem_we_o       out  1           memory write enable
//  mem_byte_op_o  out  1           1 = byte op, 0 = word op (memory aligns word ops to addr & ~3)
//  mem_addr_o     out  ADDR_WIDTH  memory byte address
//  mem_wd_o       out  DATA_WIDTH  write data; byte ops use [BYTE_WIDTH-1:0]
//  mem_rd_i       in   DATA_WIDTH  read data, combinational from mem_addr_o/mem_byte_op_o
// BEHAVIOUR
//  Reset: state IDLE; req_ready_o=1; all other outputs 0. Reset mid-op aborts at once; mem_we_o
//   drops asynchronously; byte writes already done on earlier negedges stay (partial store).
//  FSM: IDLE -> ACCESS (legal, on accept) | RESP (error, on accept); ACCESS -> RESP after last op;
//   RESP -> IDLE. Request latched on accept; req_* ignored outside IDLE.
//  Ops per request (one per cycle in ACCESS, byte counter k=0..N-1):
//   LW/SW aligned: 1 word op at addr. LB/LBU/SB: 1 byte op at addr.
//   LH/LHU/SH: 2 byte ops at addr+k (always byte ops, including even addresses).
//  Little-endian: store byte op k drives mem_wd_o[7:0] = wdata[8k+7:8k]; load byte op k captures
//   mem_rd_i[7:0] into assembly byte k on the posedge ending that cycle.
//  mem_* driven from registered state; stable before negedge so memory writes in same cycle.
//   Outside ACCESS: mem_we_o=0, mem_byte_op_o=0, mem_addr_o=0, mem_wd_o=0.
//  Latency accept->rsp_valid_o: N+1 cycles (LW/LB: 2, LH: 3); error: 1 cycle, no memory op.
//  Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW as-is.
//  Errors: funct3 not in {000,001,010,100,101} for loads / {000,001,010} for stores -> rsp_err_o=1.
//  Address arithmetic addr+k wraps modulo 2**ADDR_WIDTH.
// CONFIGURATION
//  LSU_MISALIGNED_SPLIT_EN defined: LW/SW with addr[1:0]!=0 -> 4 byte ops at addr+0..3, latency 5.
//   Halfwords never misaligned (already byte-split).
//  Not defined: LW/SW addr[1:0]!=0 and LH/LHU/SH addr[0]=1 -> error response, no memory op.
// STRUCTURE
//  lsu_pkg: lsu_state_e {IDLE,ACCESS,RESP}; funct3 localparams (F3_B,F3_H,F3_W,F3_BU,F3_HU);
//   BYTES_PER_WORD constant; function is_legal_funct3(we,funct3).
//  Sub-module lsu_load_align: combinational assembly register view + sign/zero extension by funct3.
// TESTING
//  1 SW 0xDEADBEEF @0x10004 then LW @0x10004 -> one word op each; rdata 0xDEADBEEF, latency 2.
//  2 SB 0x..80 @0x10001, LB/LBU @0x10001 -> 0xFFFFFF80 / 0x00000080; other bytes of word untouched.
//  3 SH 0x8001 @0x10002 -> byte ops 0x10002=0x01, 0x10003=0x80; LH -> 0xFFFF8001, LHU -> 0x00008001.
//  4 LW @0x10001: with LSU_MISALIGNED_SPLIT_EN 4 byte ops, latency 5, correct bytes; without ->
//    rsp_err_o=1 one cycle after accept, mem_we_o never high.
//  5 funct3=011 load -> rsp_err_o=1, no mem op; req_valid_i held during ACCESS -> not re-accepted.
//  6 rst_ni low during SW split after byte 1 -> bytes 0-1 written, 2-3 unchanged; outputs reset values.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32I funct3
// codes, and the funct3 legality check.
package lsu_pkg;

  localparam int LSU_DATA_WIDTH = 32;
  localparam int LSU_BYTE_WIDTH = 8;
  localparam int LSU_ADDR_WIDTH = 32;
  localparam int BYTES_PER_WORD = LSU_DATA_WIDTH / LSU_BYTE_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic is_legal_funct3(input logic we, input logic [2:0] funct3);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// CPU request/response and data-memory signals of the load/store unit.
// master = the LSU itself, slave = the CPU/memory environment around it.
interface lsu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [2:0]            req_funct3_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic                  rsp_valid_o;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  rsp_err_o;
  logic                  mem_we_o;
  logic                  mem_byte_op_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wd_o;
  logic [DATA_WIDTH-1:0] mem_rd_i;

  modport master (
    input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, mem_rd_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           mem_we_o, mem_byte_op_o, mem_addr_o, mem_wd_o
  );

  modport slave (
    output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, mem_rd_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           mem_we_o, mem_byte_op_o, mem_addr_o, mem_wd_o
  );
endinterface

// File: rtl/lsu_load_align.sv
// Turns the little-endian load assembly register into the architectural
// result: sign/zero extension selected by funct3.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = LSU_DATA_WIDTH,
  parameter int BYTE_WIDTH = LSU_BYTE_WIDTH
) (
  input  logic [2:0]            i_funct3,
  input  logic [DATA_WIDTH-1:0] i_asm,
  output logic [DATA_WIDTH-1:0] o_data
);
  localparam int HW = 2 * BYTE_WIDTH;

  always_comb begin
    o_data = i_asm;
    case (i_funct3)
      F3_B:  o_data = {{(DATA_WIDTH-BYTE_WIDTH){i_asm[BYTE_WIDTH-1]}}, i_asm[BYTE_WIDTH-1:0]};
      F3_BU: o_data = {{(DATA_WIDTH-BYTE_WIDTH){1'b0}}, i_asm[BYTE_WIDTH-1:0]};
      F3_H:  o_data = {{(DATA_WIDTH-HW){i_asm[HW-1]}}, i_asm[HW-1:0]};
      F3_HU: o_data = {{(DATA_WIDTH-HW){1'b0}}, i_asm[HW-1:0]};
      default: o_data = i_asm;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: sequences one CPU request into word/byte memory ops and
// returns a one-cycle response. Optional build macro: LSU_MISALIGNED_SPLIT_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = LSU_DATA_WIDTH,
  parameter int BYTE_WIDTH = LSU_BYTE_WIDTH,
  parameter int ADDR_WIDTH = LSU_ADDR_WIDTH
) (
  input logic   clk_i,
  input logic   rst_ni,
  lsu_if.master bus
);
  localparam int BPW = DATA_WIDTH / BYTE_WIDTH;
  localparam int LGB = $clog2(BPW);
  localparam int KW  = LGB + 1;

  lsu_state_e            r_state, w_state_nxt;
  logic                  r_we, r_err, r_byte;
  logic [2:0]            r_f3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_asm;
  logic [KW-1:0]         r_k, r_nops;

  logic                  w_accept, w_err, w_byte, w_size_h, w_size_w, w_mis_w, w_mis_h;
  logic [KW-1:0]         w_nops;
  logic [LGB-1:0]        w_kb;
  logic [BYTE_WIDTH-1:0] w_wbyte;
  logic [DATA_WIDTH-1:0] w_ldata;

  assign w_accept = bus.req_valid_i && (r_state == IDLE);
  assign w_size_h = (bus.req_funct3_i[1:0] == 2'b01);
  assign w_size_w = (bus.req_funct3_i[1:0] == 2'b10);
  assign w_mis_w  = |bus.req_addr_i[LGB-1:0];
  assign w_mis_h  = bus.req_addr_i[0];
  assign w_kb     = r_k[LGB-1:0];

  // Halfwords are always byte-split, so only words differ between builds.
`ifdef LSU_MISALIGNED_SPLIT_EN
  assign w_err  = !is_legal_funct3(bus.req_we_i, bus.req_funct3_i);
  assign w_byte = !(w_size_w && !w_mis_w);
  assign w_nops = w_size_w ? (w_mis_w ? KW'(BPW) : KW'(1)) : (w_size_h ? KW'(2) : KW'(1));
`else
  assign w_err  = !is_legal_funct3(bus.req_we_i, bus.req_funct3_i)
                  || (w_size_w && w_mis_w) || (w_size_h && w_mis_h);
  assign w_byte = !w_size_w;
  assign w_nops = w_size_h ? KW'(2) : KW'(1);
`endif

  always_comb begin
    w_wbyte = '0;
    for (int b = 0; b < BPW; b++)
      if (w_kb == LGB'(b)) w_wbyte = r_wdata[b*BYTE_WIDTH +: BYTE_WIDTH];
  end

  lsu_load_align #(.DATA_WIDTH(DATA_WIDTH), .BYTE_WIDTH(BYTE_WIDTH)) u_align (
    .i_funct3 (r_f3),
    .i_asm    (r_asm),
    .o_data   (w_ldata)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_byte  <= 1'b0;
      r_f3    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_asm   <= '0;
      r_k     <= '0;
      r_nops  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_we    <= bus.req_we_i;
        r_f3    <= bus.req_funct3_i;
        r_addr  <= bus.req_addr_i;
        r_wdata <= bus.req_wdata_i;
        r_err   <= w_err;
        r_byte  <= w_byte;
        r_nops  <= w_nops;
        r_k     <= '0;
        r_asm   <= '0;
      end else if (r_state == ACCESS) begin
        r_k <= r_k + KW'(1);
        // Memory read is combinational, so this cycle's op result is captured here.
        if (!r_we) begin
          if (r_byte) begin
            for (int b = 0; b < BPW; b++)
              if (w_kb == LGB'(b)) r_asm[b*BYTE_WIDTH +: BYTE_WIDTH] <= bus.mem_rd_i[BYTE_WIDTH-1:0];
          end else begin
            r_asm <= bus.mem_rd_i;
          end
        end
      end
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    bus.req_ready_o   = 1'b0;
    bus.rsp_valid_o   = 1'b0;
    bus.rsp_rdata_o   = '0;
    bus.rsp_err_o     = 1'b0;
    bus.mem_we_o      = 1'b0;
    bus.mem_byte_op_o = 1'b0;
    bus.mem_addr_o    = '0;
    bus.mem_wd_o      = '0;
    case (r_state)
      IDLE: begin
        bus.req_ready_o = 1'b1;
        if (w_accept) w_state_nxt = w_err ? RESP : ACCESS;
      end
      ACCESS: begin
        bus.mem_we_o      = r_we;
        bus.mem_byte_op_o = r_byte;
        bus.mem_addr_o    = r_byte ? (r_addr + ADDR_WIDTH'(r_k)) : r_addr;
        bus.mem_wd_o      = r_byte ? {{(DATA_WIDTH-BYTE_WIDTH){1'b0}}, w_wbyte} : r_wdata;
        if (r_k == r_nops - KW'(1)) w_state_nxt = RESP;
      end
      RESP: begin
        bus.rsp_valid_o = 1'b1;
        bus.rsp_err_o   = r_err;
        bus.rsp_rdata_o = (r_err || r_we) ? '0 : w_ldata;
        w_state_nxt     = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule
